addr_arb: RTL and testbench
===========================

ADDR_ARB -- requirements
Module: addr_arb

Interface
REQ-001 Parameter ADDR_W, default 13, width of every address (8K-byte space).
REQ-002 Parameter N_CH, default 3, number of requesting channels (ch0 = PC fetch, ch1 = IR data/port, ch2 = spare); legal 2..8.
REQ-003 Parameter RR_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 Parameter TMO, default 15, max BUSY cycles awaiting bus_ack before abort; legal 1..255.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req  in  N_CH  per-channel request level; held by requester until its done or err pulse.
REQ-009 addr_in  in  N_CH*ADDR_W  packed channel addresses, channel k at bits [k*ADDR_W +: ADDR_W].
REQ-010 we_in  in  N_CH  per-channel write enable accompanying the request.
REQ-011 bus_ack  in  1  memory/port completion strobe.
REQ-012 bus_addr  out  ADDR_W  registered selected address.
REQ-013 bus_we  out  1  registered selected write enable.
REQ-014 bus_valid  out  1  high while a transaction is presented.
REQ-015 gnt  out  N_CH  one-hot grant of the channel owning the bus.
REQ-016 done  out  N_CH  one-cycle completion pulse to the owning channel.
REQ-017 err  out  N_CH  one-cycle timeout-abort pulse to the owning channel.

Function
REQ-018 FSM SHALL have two states: IDLE, BUSY.
REQ-019 In IDLE with req != 0, at the clock edge the block SHALL pick a winner, load bus_addr/bus_we from that channel, set gnt one-hot, bus_valid = 1, clear the timeout counter, enter BUSY.
REQ-020 In IDLE with req == 0, bus_valid and gnt SHALL be 0; bus_addr/bus_we SHALL hold their last values.
REQ-021 RR_MODE = 0: winner = lowest-index asserted req.
REQ-022 RR_MODE = 1: winner = first asserted req at or after pointer ptr, searching upward with wrap from N_CH-1 to 0; ptr resets to 0 and becomes winner+1 (mod N_CH) on each completion or abort.
REQ-023 In BUSY, bus_addr, bus_we, gnt, bus_valid SHALL remain stable regardless of req/addr_in/we_in changes.
REQ-024 In BUSY with bus_ack = 1 at the edge: done[owner] pulses 1 cycle, bus_valid and gnt clear, state returns to IDLE.
REQ-025 In BUSY with bus_ack = 0 the counter increments; when it reaches TMO with no ack, err[owner] pulses 1 cycle, bus_valid and gnt clear, state returns to IDLE.
REQ-026 bus_ack on the same edge as counter == TMO SHALL be treated as completion (done, not err).
REQ-027 bus_ack while IDLE SHALL be ignored.
REQ-028 Owner dropping req during BUSY SHALL NOT abort; the transaction completes or times out normally.
REQ-029 Minimum spacing SHALL be one IDLE cycle between transactions; a grant occurs at earliest the second edge after done/err.
REQ-030 done and err SHALL never both be set, and at most one bit of each SHALL be set per cycle.
REQ-031 Latency req-to-bus_valid SHALL be exactly 1 clock from IDLE.

Reset
REQ-032 On rst = 1 at an edge: state = IDLE, bus_addr = 0, bus_we = 0, bus_valid = 0, gnt = 0, done = 0, err = 0, counter = 0, ptr = 0.
REQ-033 rst mid-BUSY SHALL abandon the transaction with no done/err pulse; rst dominates bus_ack.

Verification
REQ-034 Defaults, RR_MODE = 0: req = 3'b011, addr ch0 = 13'h0100, ch1 = 13'h1A00 -> next cycle gnt = 001, bus_addr = 13'h0100; ack -> done = 001; after one IDLE cycle gnt = 010, bus_addr = 13'h1A00.
REQ-035 RR_MODE = 1, req = 3'b111 held, ack every BUSY cycle -> grant order 001, 010, 100, 001, with done for each.
REQ-036 TMO = 4, req = 3'b010, no ack -> bus_valid high 4 cycles, then err = 010 for one cycle, done = 0, bus_valid = 0.
REQ-037 In BUSY owned by ch0, change addr_in ch0 to 13'h1FFF and drop req[0] -> bus_addr unchanged until ack, done = 001.
REQ-038 rst asserted during BUSY together with bus_ack -> next cycle all outputs 0, no done pulse; RR ptr back to 0 (next grant with req = 111 is ch0).

Source files
------------

// File: rtl/addr_arb.sv
// addr_arb: arbitrates N_CH requesting channels onto a single address bus.
// One transaction is in flight at a time. It completes on bus_ack or aborts
// after TMO cycles without an ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction presented; a pending request is granted at the edge
// BUSY  | bus_addr/bus_we/gnt frozen; waiting for bus_ack or the timeout
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req        per-channel request level, held until done/err
//   addr_in    packed channel addresses, channel k at [k*ADDR_W +: ADDR_W]
//   we_in      per-channel write enable
//   bus_ack    completion strobe from memory/port (ignored in IDLE)
//   bus_addr   registered address of the owning channel
//   bus_we     registered write enable of the owning channel
//   bus_valid  high while a transaction is presented
//   gnt        one-hot owner of the bus
//   done, err  one-cycle completion / timeout pulses to the owner
module addr_arb #(
  parameter int ADDR_W  = 13,
  parameter int N_CH    = 3,
  parameter int RR_MODE = 0,
  parameter int TMO     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   addr_in,
  input  logic [N_CH-1:0]          we_in,
  input  logic                     bus_ack,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic                     bus_we,
  output logic                     bus_valid,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          done,
  output logic [N_CH-1:0]          err
);

  localparam int PW = $clog2(N_CH);
  localparam logic [PW:0]  N_CH_W = (PW+1)'(N_CH);
  localparam logic [PW-1:0] LAST_CH = PW'(N_CH - 1);
  localparam logic [7:0]   TMO_W = 8'(TMO);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   bus_addr_d;
  logic                bus_we_d, bus_valid_d;
  logic [N_CH-1:0]     gnt_d, done_d, err_d;
  logic [PW-1:0]       owner, owner_d;
  logic [PW-1:0]       ptr, ptr_d;
  logic [PW-1:0]       base, win;
  logic [7:0]          cnt, cnt_d, cnt_inc;

  // First asserted request at or after index p, wrapping past N_CH-1.
  // Fixed priority is the same search starting from 0.
  function automatic logic [PW-1:0] pick(input logic [N_CH-1:0] r,
                                         input logic [PW-1:0]   p);
    logic [PW-1:0] sel;
    logic          found;
    logic [PW:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, p} + (PW+1)'(i);
      if (idx >= N_CH_W) idx = idx - N_CH_W;
      if (!found && r[idx[PW-1:0]]) begin
        sel   = idx[PW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    base    = (RR_MODE != 0) ? ptr : '0;
    win     = pick(req, base);
    cnt_inc = cnt + 8'd1;

    state_d     = state;
    bus_addr_d  = bus_addr;
    bus_we_d    = bus_we;
    bus_valid_d = bus_valid;
    gnt_d       = gnt;
    owner_d     = owner;
    ptr_d       = ptr;
    cnt_d       = cnt;
    done_d      = '0;
    err_d       = '0;

    case (state)
      IDLE: begin
        bus_valid_d = 1'b0;
        gnt_d       = '0;
        if (|req) begin
          owner_d     = win;
          bus_addr_d  = addr_in[win*ADDR_W +: ADDR_W];
          bus_we_d    = we_in[win];
          gnt_d[win]  = 1'b1;
          bus_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Ack wins over a timeout landing on the same edge.
        if (bus_ack || cnt_inc == TMO_W) begin
          if (bus_ack) done_d = gnt;
          else         err_d  = gnt;
          bus_valid_d = 1'b0;
          gnt_d       = '0;
          ptr_d       = (owner == LAST_CH) ? '0 : owner + 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_valid <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      owner     <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      bus_addr  <= bus_addr_d;
      bus_we    <= bus_we_d;
      bus_valid <= bus_valid_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      owner     <= owner_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_addr_arb.sv
// Directed bench for addr_arb: one fixed-priority instance (defaults) and one
// round-robin instance with TMO = 4, both driven by the same stimulus.
module tb_addr_arb;

  localparam int AW = 13;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] req;
  logic [NC*AW-1:0] addr_in;
  logic [NC-1:0] we_in;
  logic          bus_ack;

  logic [AW-1:0] f_bus_addr, r_bus_addr;
  logic          f_bus_we, r_bus_we, f_bus_valid, r_bus_valid;
  logic [NC-1:0] f_gnt, r_gnt, f_done, r_done, f_err, r_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addr_arb u_fix (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .we_in(we_in),
    .bus_ack(bus_ack), .bus_addr(f_bus_addr), .bus_we(f_bus_we),
    .bus_valid(f_bus_valid), .gnt(f_gnt), .done(f_done), .err(f_err)
  );

  addr_arb #(.RR_MODE(1), .TMO(4)) u_rr (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .we_in(we_in),
    .bus_ack(bus_ack), .bus_addr(r_bus_addr), .bus_we(r_bus_we),
    .bus_valid(r_bus_valid), .gnt(r_gnt), .done(r_done), .err(r_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    addr_in[ch*AW +: AW] = a;
  endtask

  logic [NC-1:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [NC-1:0] fp_req   [3] = '{3'b110, 3'b101, 3'b100};
  logic [NC-1:0] fp_gnt   [3] = '{3'b010, 3'b001, 3'b100};
  logic [AW-1:0] fp_addr  [3] = '{13'h1A00, 13'h0100, 13'h0555};

  initial begin
    rst = 1'b0; req = '0; addr_in = '0; we_in = '0; bus_ack = 1'b0;
    do_reset();
    tick();
    check_val("rst_f_addr",  f_bus_addr, 0);
    check_val("rst_f_valid", f_bus_valid, 0);
    check_val("rst_f_gnt",   f_gnt, 0);
    check_val("rst_f_done",  f_done, 0);
    check_val("rst_r_we",    r_bus_we, 0);
    check_val("rst_r_err",   r_err, 0);

    // Fixed priority, two back-to-back requesters.
    set_addr(0, 13'h0100); set_addr(1, 13'h1A00); set_addr(2, 13'h0555);
    we_in = 3'b010;
    req = 3'b011;
    tick();
    check_val("fp_gnt0",   f_gnt, 3'b001);
    check_val("fp_addr0",  f_bus_addr, 13'h0100);
    check_val("fp_valid0", f_bus_valid, 1);
    check_val("fp_we0",    f_bus_we, 0);
    tick();
    check_val("fp_hold_gnt", f_gnt, 3'b001);
    bus_ack = 1'b1;
    tick();
    check_val("fp_done0",  f_done, 3'b001);
    check_val("fp_valid_clr", f_bus_valid, 0);
    check_val("fp_gnt_clr", f_gnt, 0);
    bus_ack = 1'b0;
    req = 3'b010;
    tick();
    check_val("fp_gnt1",   f_gnt, 3'b010);
    check_val("fp_addr1",  f_bus_addr, 13'h1A00);
    check_val("fp_we1",    f_bus_we, 1);
    check_val("fp_done_pulse", f_done, 0);
    bus_ack = 1'b1;
    tick();
    check_val("fp_done1",  f_done, 3'b010);
    bus_ack = 1'b0;
    req = '0;
    tick();
    check_val("idle_valid", f_bus_valid, 0);
    check_val("idle_addr_hold", f_bus_addr, 13'h1A00);
    bus_ack = 1'b1;
    tick();
    check_val("idle_ack_ign", f_done, 0);
    bus_ack = 1'b0;

    // Fixed priority picks the lowest asserted index.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      req = fp_req[k];
      tick();
      check_val("fp_pri_gnt",  f_gnt, fp_gnt[k]);
      check_val("fp_pri_addr", f_bus_addr, fp_addr[k]);
      req = '0;
    end

    // Round-robin rotation with all channels requesting and ack held.
    do_reset();
    req = 3'b111;
    bus_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("rr_gnt", r_gnt, rr_order[k]);
      check_val("fix_gnt", f_gnt, 3'b001);
      tick();
      check_val("rr_done", r_done, rr_order[k]);
    end
    bus_ack = 1'b0;
    req = '0;
    tick();

    // Timeout with TMO = 4.
    do_reset();
    req = 3'b010;
    tick();
    check_val("to_gnt", r_gnt, 3'b010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("to_valid", r_bus_valid, 1);
      check_val("to_err_early", r_err, 0);
    end
    tick();
    check_val("to_err",   r_err, 3'b010);
    check_val("to_done",  r_done, 0);
    check_val("to_valid_clr", r_bus_valid, 0);
    req = '0;
    tick();
    check_val("to_err_pulse", r_err, 0);

    // Ack on the timeout edge counts as completion.
    do_reset();
    req = 3'b010;
    tick();
    tick(); tick(); tick();
    bus_ack = 1'b1;
    tick();
    check_val("tb_done", r_done, 3'b010);
    check_val("tb_err",  r_err, 0);
    bus_ack = 1'b0;
    req = '0;
    tick();

    // Inputs change under a BUSY owner.
    do_reset();
    we_in = 3'b000;
    set_addr(0, 13'h0100);
    req = 3'b001;
    tick();
    set_addr(0, 13'h1FFF);
    we_in = 3'b001;
    req = '0;
    tick();
    check_val("st_addr", f_bus_addr, 13'h0100);
    check_val("st_we",   f_bus_we, 0);
    check_val("st_gnt",  f_gnt, 3'b001);
    tick();
    check_val("st_valid", f_bus_valid, 1);
    bus_ack = 1'b1;
    tick();
    check_val("st_done", f_done, 3'b001);
    check_val("st_addr_end", f_bus_addr, 13'h0100);
    bus_ack = 1'b0;

    // Reset mid-BUSY with ack; round-robin pointer returns to 0.
    do_reset();
    req = 3'b001;
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    req = 3'b111;
    tick();
    check_val("rb_gnt_pre", r_gnt, 3'b010);
    rst = 1'b1;
    bus_ack = 1'b1;
    tick();
    check_val("rb_done", r_done, 0);
    check_val("rb_valid", r_bus_valid, 0);
    check_val("rb_gnt", r_gnt, 0);
    check_val("rb_addr", r_bus_addr, 0);
    rst = 1'b0;
    bus_ack = 1'b0;
    tick();
    check_val("rb_ptr0", r_gnt, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
